// File: rtl/memory_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM encodings and the
// default bus watchdog limit.
package memory_access_stage_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_BUSY = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_t;

  // BUSY cycles allowed without an ack before the access is aborted.
  localparam int MEM_TIMEOUT_DEFAULT = 16;

  // A word access must have its two low address bits clear.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/memory_access_stage_watchdog.sv
// Bus watchdog: counts BUSY cycles without an ack and flags the last
// allowed cycle so the stage can abort the access.
module mem_bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Clear,
  input  logic i_Enable,
  output logic o_Expired
);

  logic [CNT_W-1:0] count;

  // Counter: clear has priority over enable; holds otherwise.
  always_ff @(posedge i_Clk) begin
    if (i_Rst || i_Clear) begin
      count <= '0;
    end else if (i_Enable) begin
      count <= count + 1'b1;
    end
  end

  // Expired marks the final BUSY cycle the access is allowed to wait.
  always_comb begin
    o_Expired = (count == CNT_W'(TIMEOUT_CYCLES - 1));
  end

endmodule

// File: rtl/memory_access_stage.sv
// Pipeline MEM stage. Issues LD/ST bus cycles, stalls the pipeline until
// each completes, traps misaligned addresses and aborts unacked cycles.
//
// Bus handshake: o_MemReq is held high for every BUSY cycle with o_MemAddr,
// o_MemWrEn and o_MemWrData stable; the slave completes the cycle with a
// single-cycle i_MemAck (carrying i_MemRdData on reads). An ack seen while
// no request is outstanding is ignored.
module memory_access_stage
  import memory_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT,
  localparam int CNT_W         = $clog2(TIMEOUT_CYCLES)
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic [31:0] i_AluOut,
  input  logic [31:0] i_StoreData,
  output logic        o_MemReq,
  output logic        o_MemWrEn,
  output logic [31:0] o_MemAddr,
  output logic [31:0] o_MemWrData,
  input  logic        i_MemAck,
  input  logic [31:0] i_MemRdData,
  output logic [31:0] o_LoadData,
  output logic        o_Stall,
  output logic        o_BusError,
  output logic [31:0] o_ErrAddr,
  output logic [1:0]  o_DbgState
);

  mem_state_t state, state_nxt;
  logic       op;
  logic       misaligned;
  logic       err;
  logic       wd_clear;
  logic       wd_en;
  logic       wd_expired;

  assign op         = i_MemRead | i_MemWrite;
  assign misaligned = is_misaligned(i_AluOut);

  mem_bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_Clear   (wd_clear),
    .i_Enable  (wd_en),
    .o_Expired (wd_expired)
  );

  // State register.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state <= MEM_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and watchdog control; ack beats a coincident timeout.
  always_comb begin
    state_nxt = state;
    wd_clear  = 1'b0;
    wd_en     = 1'b0;
    case (state)
      MEM_IDLE: begin
        wd_clear = 1'b1;
        if (op) begin
          state_nxt = misaligned ? MEM_DONE : MEM_BUSY;
        end
      end
      MEM_BUSY: begin
        if (i_MemAck || wd_expired) begin
          state_nxt = MEM_DONE;
        end else begin
          wd_en = 1'b1;
        end
      end
      MEM_DONE: state_nxt = MEM_IDLE;
      default:  state_nxt = MEM_IDLE;
    endcase
  end

  // Bus latches, load result and error capture.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      o_MemWrEn   <= 1'b0;
      o_MemAddr   <= '0;
      o_MemWrData <= '0;
      o_LoadData  <= '0;
      o_ErrAddr   <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        MEM_IDLE: begin
          if (op) begin
            if (misaligned) begin
              err        <= 1'b1;
              o_LoadData <= '0;
              o_ErrAddr  <= i_AluOut;
            end else begin
              o_MemAddr   <= i_AluOut;
              o_MemWrData <= i_StoreData;
              o_MemWrEn   <= i_MemWrite;
            end
          end
        end
        MEM_BUSY: begin
          if (i_MemAck) begin
            if (!o_MemWrEn) begin
              o_LoadData <= i_MemRdData;
            end
          end else if (wd_expired) begin
            err        <= 1'b1;
            o_LoadData <= '0;
            o_ErrAddr  <= o_MemAddr;
          end
        end
        MEM_DONE: err <= 1'b0;
        default:  err <= 1'b0;
      endcase
    end
  end

  // Request, stall and error pulse follow directly from the state.
  always_comb begin
    o_MemReq   = (state == MEM_BUSY);
    o_Stall    = ((state == MEM_IDLE) && op) || (state == MEM_BUSY);
    o_BusError = (state == MEM_DONE) && err;
    o_DbgState = state;
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for the MEM stage: loads, stores, misaligned trap,
// watchdog timeout, reset mid-access and back-to-back loads.
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] alu_out, store_data;
  logic        mem_req, mem_wr_en;
  logic [31:0] mem_addr, mem_wr_data;
  logic        mem_ack;
  logic [31:0] mem_rd_data;
  logic [31:0] load_data;
  logic        stall, bus_error;
  logic [31:0] err_addr;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  int req_count = 0;
  logic req_prev = 1'b0;

  memory_access_stage #(.TIMEOUT_CYCLES(16)) dut (
    .i_Clk       (clk),
    .i_Rst       (rst),
    .i_MemRead   (mem_read),
    .i_MemWrite  (mem_write),
    .i_AluOut    (alu_out),
    .i_StoreData (store_data),
    .o_MemReq    (mem_req),
    .o_MemWrEn   (mem_wr_en),
    .o_MemAddr   (mem_addr),
    .o_MemWrData (mem_wr_data),
    .i_MemAck    (mem_ack),
    .i_MemRdData (mem_rd_data),
    .o_LoadData  (load_data),
    .o_Stall     (stall),
    .o_BusError  (bus_error),
    .o_ErrAddr   (err_addr),
    .o_DbgState  (dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Count bus requests as rising edges of o_MemReq, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_req && !req_prev) req_count++;
    req_prev <= mem_req;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_op(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] sdata);
    mem_read   = rd;
    mem_write  = wr;
    alu_out    = addr;
    store_data = sdata;
  endtask

  task automatic idle_op();
    drive_op(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    int req_base;
    rst         = 1'b1;
    mem_ack     = 1'b0;
    mem_rd_data = 32'h0;
    idle_op();

    // Reset.
    step();
    step();
    #1;
    chk("rst_req",   32'(mem_req),   32'd0);
    chk("rst_stall", 32'(stall),     32'd0);
    chk("rst_load",  load_data,      32'd0);
    chk("rst_erra",  err_addr,       32'd0);
    chk("rst_berr",  32'(bus_error), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    step();

    // Non-memory instruction: no stall.
    chk("nop_stall", 32'(stall), 32'd0);

    // LD 0x40, ack on second BUSY cycle.
    drive_op(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    #1;
    chk("ld_idle_stall", 32'(stall),   32'd1);
    chk("ld_idle_req",   32'(mem_req), 32'd0);
    step();
    chk("ld_b1_req",   32'(mem_req),   32'd1);
    chk("ld_b1_wren",  32'(mem_wr_en), 32'd0);
    chk("ld_b1_addr",  mem_addr,       32'h0000_0040);
    chk("ld_b1_stall", 32'(stall),     32'd1);
    step();
    chk("ld_b2_req", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rd_data = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0; mem_rd_data = 32'h0;
    chk("ld_done_req",   32'(mem_req),   32'd0);
    chk("ld_done_stall", 32'(stall),     32'd0);
    chk("ld_done_data",  load_data,      32'hDEAD_BEEF);
    chk("ld_done_berr",  32'(bus_error), 32'd0);
    step();
    idle_op();
    #1;
    chk("ld_after_state", 32'(dbg_state), 32'd0);
    chk("ld_req_count",   32'(req_count), 32'd1);

    // ST 0x12345678 to 0x100, immediate ack; read data must be ignored.
    drive_op(1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678);
    step();
    chk("st_wren",  32'(mem_wr_en), 32'd1);
    chk("st_wdata", mem_wr_data,     32'h1234_5678);
    chk("st_addr",  mem_addr,        32'h0000_0100);
    mem_ack = 1'b1; mem_rd_data = 32'hFFFF_FFFF;
    step();
    mem_ack = 1'b0;
    chk("st_done_stall", 32'(stall), 32'd0);
    chk("st_done_load",  load_data,  32'hDEAD_BEEF);
    step();
    idle_op();

    // Read and write together behave as a write.
    drive_op(1'b1, 1'b1, 32'h0000_0500, 32'hA5A5_5A5A);
    step();
    chk("rw_wren", 32'(mem_wr_en), 32'd1);
    mem_ack = 1'b1; mem_rd_data = 32'h0BAD_0BAD;
    step();
    mem_ack = 1'b0;
    chk("rw_load", load_data, 32'hDEAD_BEEF);
    step();
    idle_op();

    // Misaligned LD 0x42: trapped, no bus cycle.
    req_base = req_count;
    drive_op(1'b1, 1'b0, 32'h0000_0042, 32'h0);
    #1;
    chk("mis_idle_req", 32'(mem_req), 32'd0);
    step();
    chk("mis_done_req",   32'(mem_req),   32'd0);
    chk("mis_done_state", 32'(dbg_state), 32'd2);
    chk("mis_berr",       32'(bus_error), 32'd1);
    chk("mis_erra",       err_addr,       32'h0000_0042);
    chk("mis_load",       load_data,      32'd0);
    chk("mis_stall",      32'(stall),     32'd0);
    step();
    idle_op();
    #1;
    chk("mis_berr_clear", 32'(bus_error),            32'd0);
    chk("mis_no_req",     32'(req_count - req_base), 32'd0);

    // LD 0x200 with ack on the 16th BUSY cycle: ack beats the timeout.
    drive_op(1'b1, 1'b0, 32'h0000_0200, 32'h0);
    step();
    for (int i = 0; i < 16; i++) begin
      chk("tack_req", 32'(mem_req), 32'd1);
      if (i == 15) begin
        mem_ack = 1'b1; mem_rd_data = 32'hCAFE_F00D;
      end
      step();
    end
    mem_ack = 1'b0;
    chk("tack_berr", 32'(bus_error), 32'd0);
    chk("tack_load", load_data,      32'hCAFE_F00D);
    chk("tack_erra", err_addr,       32'h0000_0042);
    step();
    idle_op();

    // LD 0x200 with no ack: 16 request cycles then a timeout error.
    drive_op(1'b1, 1'b0, 32'h0000_0200, 32'h0);
    step();
    for (int i = 0; i < 16; i++) begin
      chk("tmo_req", 32'(mem_req), 32'd1);
      step();
    end
    chk("tmo_req_end", 32'(mem_req),   32'd0);
    chk("tmo_berr",    32'(bus_error), 32'd1);
    chk("tmo_erra",    err_addr,       32'h0000_0200);
    chk("tmo_load",    load_data,      32'd0);
    step();
    idle_op();
    #1;
    chk("tmo_berr_clear", 32'(bus_error), 32'd0);

    // Reset in BUSY, then a late ack that must be ignored.
    drive_op(1'b1, 1'b0, 32'h0000_0300, 32'h0);
    step();
    chk("rb_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_op();
    mem_ack = 1'b1; mem_rd_data = 32'h5555_AAAA;
    #1;
    chk("rb_state", 32'(dbg_state), 32'd0);
    chk("rb_req0",  32'(mem_req),   32'd0);
    chk("rb_addr",  mem_addr,       32'd0);
    chk("rb_erra",  err_addr,       32'd0);
    step();
    mem_ack = 1'b0;
    chk("rb_late_state", 32'(dbg_state), 32'd0);
    chk("rb_late_load",  load_data,      32'd0);
    chk("rb_late_berr",  32'(bus_error), 32'd0);
    chk("rb_add_stall",  32'(stall),     32'd0);
    step();

    // Back-to-back LD, LD: one request each, DONE in between.
    req_base = req_count;
    drive_op(1'b1, 1'b0, 32'h0000_0400, 32'h0);
    step();
    mem_ack = 1'b1; mem_rd_data = 32'h1111_1111;
    step();
    mem_ack = 1'b0;
    chk("bb_done1_state", 32'(dbg_state), 32'd2);
    chk("bb_done1_stall", 32'(stall),     32'd0);
    chk("bb_done1_load",  load_data,      32'h1111_1111);
    step();
    alu_out = 32'h0000_0404;
    #1;
    chk("bb_idle2_state", 32'(dbg_state), 32'd0);
    chk("bb_idle2_stall", 32'(stall),     32'd1);
    step();
    chk("bb_b2_addr", mem_addr, 32'h0000_0404);
    mem_ack = 1'b1; mem_rd_data = 32'h2222_2222;
    step();
    mem_ack = 1'b0;
    chk("bb_done2_load", load_data, 32'h2222_2222);
    step();
    idle_op();
    step();
    chk("bb_req_count", 32'(req_count - req_base), 32'd2);
    chk("bb_end_state", 32'(dbg_state),            32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
